// File: rtl/c432_irq_seq_if.sv
// Bus between the upstream priority encoder / CPU and c432_irq_seq.
// The slave modport is the sequencer's view; master is the driver's view.
interface c432_irq_seq_if;
    logic [2:0] GRANT;
    logic [3:0] CHAN;
    logic       IACK;
    logic       EOI;
    logic       IRQ;
    logic [6:0] VEC;
    logic       BUSY;
    logic [2:0] CNT;
    logic       OVF;

    modport master (
        output GRANT, CHAN, IACK, EOI,
        input  IRQ, VEC, BUSY, CNT, OVF
    );

    modport slave (
        input  GRANT, CHAN, IACK, EOI,
        output IRQ, VEC, BUSY, CNT, OVF
    );
endinterface

// File: rtl/c432_irq_seq.sv
// Interrupt request sequencer: edge-captures encoder grants, queues them and hands them to the CPU.
// Define C432_IRQ_SEQ_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module c432_irq_seq #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           CK,
    input logic           RST,
    c432_irq_seq_if.slave bus
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..8");
    end

    typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

    state_e     state_q, state_d;
    logic [6:0] s, prev_q, vreg_q, vreg_d, head, vec;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       cap, pop, push, full;

    assign s    = {bus.GRANT, bus.CHAN};
    assign cap  = (bus.GRANT != 3'b000) && (s != prev_q);
    assign pop  = (state_q == StReq) && bus.IACK;
    // A pop in the same cycle frees the slot the capture needs.
    assign push = cap && (!full || pop);

`ifdef C432_IRQ_SEQ_FIFO_EN
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  Full = 4'(FIFO_DEPTH);

    logic [6:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

    assign full = (cnt_q == Full);
    assign head = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge CK) begin
        if (!RST && push) mem_q[wptr_q] <= s;
    end
`else
    logic [6:0] hold_q;

    assign full = (cnt_q != 4'd0);
    assign head = hold_q;

    always_ff @(posedge CK) begin
        if (!RST && push) hold_q <= s;
    end
`endif

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | (cap && !push);
        state_d = state_q;
        vreg_d  = vreg_q;
        if (push && !pop)      cnt_d = cnt_q + 4'd1;
        else if (pop && !push) cnt_d = cnt_q - 4'd1;
        unique case (state_q)
            StIdle: if (cnt_q != 4'd0) state_d = StReq;
            StReq: begin
                if (bus.IACK) begin
                    state_d = StServ;
                    vreg_d  = head;
                end
            end
            StServ:  if (bus.EOI) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= StIdle;
            prev_q  <= '0;
            vreg_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= s;
            vreg_q  <= vreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        vec = 7'h00;
        unique case (state_q)
            StReq:   vec = head;
            StServ:  vec = vreg_q;
            default: vec = 7'h00;
        endcase
    end

    assign bus.IRQ  = (state_q == StReq);
    assign bus.BUSY = (state_q != StIdle);
    assign bus.VEC  = vec;
    // The port is 3 bits wide; a full depth-8 queue reports 7.
    assign bus.CNT  = (cnt_q > 4'd7) ? 3'd7 : cnt_q[2:0];
    assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_c432_irq_seq.sv
// Randomised scoreboard bench for c432_irq_seq against a queue-based reference model.
module tb_c432_irq_seq;

`ifdef C432_IRQ_SEQ_FIFO_EN
    localparam int unsigned MDepth = 4;
`else
    localparam int unsigned MDepth = 1;
`endif

    typedef struct packed {
        logic       irq;
        logic       busy;
        logic [6:0] vec;
        logic [2:0] cnt;
        logic       ovf;
    } exp_t;

    logic ck = 1'b0;
    logic rst = 1'b1;
    c432_irq_seq_if bus_if ();

    c432_irq_seq #(.FIFO_DEPTH(4)) dut (
        .CK  (ck),
        .RST (rst),
        .bus (bus_if)
    );

    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 requesting, 2 in service.
    int unsigned mst = 0;
    logic [6:0]  mq[$];
    logic [6:0]  sb_q[$];
    exp_t        exp_q[$];
    logic [6:0]  mprev = 7'h00;
    logic [6:0]  mvreg = 7'h00;
    logic        movf = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [6:0] v, input logic ia, input logic eo);
        exp_t e;
        logic cap, nonempty;
        if (r) begin
            mst = 0;
            mq.delete();
            sb_q.delete();
            mprev = 7'h00;
            mvreg = 7'h00;
            movf  = 1'b0;
        end else begin
            cap      = (v[6:4] != 3'b000) && (v != mprev);
            mprev    = v;
            nonempty = (mq.size() != 0);
            if (mst == 1 && ia) mvreg = mq.pop_front();
            if (cap) begin
                if (mq.size() < MDepth) begin
                    mq.push_back(v);
                    sb_q.push_back(v);
                end else begin
                    movf = 1'b1;
                end
            end
            case (mst)
                0: if (nonempty) mst = 1;
                1: if (ia) mst = 2;
                default: if (eo) mst = 0;
            endcase
        end
        e.irq  = (mst == 1);
        e.busy = (mst != 0);
        e.vec  = (mst == 1) ? mq[0] : (mst == 2) ? mvreg : 7'h00;
        e.cnt  = 3'(mq.size());
        e.ovf  = movf;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, record the expected post-edge state, then wait past the edge.
    task automatic step(input logic r, input logic [6:0] v, input logic ia, input logic eo);
        rst          = r;
        bus_if.GRANT = v[6:4];
        bus_if.CHAN  = v[3:0];
        bus_if.IACK  = ia;
        bus_if.EOI   = eo;
        model_edge(r, v, ia, eo);
        @(posedge ck);
        #2;
    endtask

    // Per-cycle output monitor.
    initial begin : mon_state
        exp_t e;
        forever begin
            @(posedge ck);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("irq",  int'(bus_if.IRQ),  int'(e.irq));
                chk("busy", int'(bus_if.BUSY), int'(e.busy));
                chk("vec",  int'(bus_if.VEC),  int'(e.vec));
                chk("cnt",  int'(bus_if.CNT),  int'(e.cnt));
                chk("ovf",  int'(bus_if.OVF),  int'(e.ovf));
            end
        end
    end

    // Handshake monitor: each acknowledged request must carry the next queued vector.
    initial begin : mon_hs
        logic [6:0] want;
        forever begin
            @(negedge ck);
            if (!rst && bus_if.IRQ && bus_if.IACK) begin
                if (sb_q.size() == 0) begin
                    chk("ack_unexpected", int'(bus_if.VEC), -1);
                end else begin
                    want = sb_q.pop_front();
                    chk("ack_vec", int'(bus_if.VEC), int'(want));
                end
            end
        end
    end

    initial begin
        logic [6:0] v;
        logic       r, ia, eo;
        step(1'b1, 7'h00, 1'b0, 1'b0);
        step(1'b1, 7'h00, 1'b0, 1'b0);
        chk("rst_cnt", int'(bus_if.CNT), 0);
        chk("rst_irq", int'(bus_if.IRQ), 0);

        // Single request through the whole handshake.
        step(1'b0, 7'h15, 1'b0, 1'b0);
        chk("d1_cnt", int'(bus_if.CNT), 1);
        chk("d1_irq_early", int'(bus_if.IRQ), 0);
        step(1'b0, 7'h00, 1'b0, 1'b0);
        chk("d1_irq", int'(bus_if.IRQ), 1);
        chk("d1_vec", int'(bus_if.VEC), 'h15);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        chk("d1_busy", int'(bus_if.BUSY), 1);
        chk("d1_irq_ack", int'(bus_if.IRQ), 0);
        step(1'b0, 7'h00, 1'b0, 1'b1);
        chk("d1_vec_eoi", int'(bus_if.VEC), 0);
        chk("d1_busy_eoi", int'(bus_if.BUSY), 0);

        // Held level is captured once.
        for (int i = 0; i < 10; i++) step(1'b0, 7'h23, 1'b0, 1'b0);
        chk("d2_cnt", int'(bus_if.CNT), 1);
        step(1'b0, 7'h00, 1'b1, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b1);
        step(1'b1, 7'h00, 1'b0, 1'b0);

`ifdef C432_IRQ_SEQ_FIFO_EN
        for (int i = 1; i <= 5; i++) step(1'b0, 7'(7'h10 + i), 1'b0, 1'b0);
        chk("d3_cnt", int'(bus_if.CNT), 4);
        chk("d3_ovf", int'(bus_if.OVF), 1);
        chk("d3_vec", int'(bus_if.VEC), 'h11);
        // Capture coincident with a pop at full.
        step(1'b0, 7'h16, 1'b1, 1'b0);
        chk("d4_cnt", int'(bus_if.CNT), 4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 7'h00, 1'b0, 1'b1);
            step(1'b0, 7'h00, 1'b0, 1'b0);
            step(1'b0, 7'h00, 1'b1, 1'b0);
        end
        chk("d4_busy", int'(bus_if.BUSY), 1);
`else
        step(1'b0, 7'h21, 1'b0, 1'b0);
        step(1'b0, 7'h22, 1'b0, 1'b0);
        chk("d6_cnt", int'(bus_if.CNT), 1);
        chk("d6_vec", int'(bus_if.VEC), 'h21);
        chk("d6_ovf", int'(bus_if.OVF), 1);
        step(1'b0, 7'h23, 1'b1, 1'b0);
        chk("d6_busy", int'(bus_if.BUSY), 1);
`endif
        // Reset while in service.
        step(1'b1, 7'h00, 1'b0, 1'b0);
        chk("d5_cnt", int'(bus_if.CNT), 0);
        chk("d5_irq", int'(bus_if.IRQ), 0);
        chk("d5_vec", int'(bus_if.VEC), 0);
        chk("d5_ovf", int'(bus_if.OVF), 0);
        chk("d5_busy", int'(bus_if.BUSY), 0);

        // Random traffic; small channel range keeps repeats and overflows frequent.
        for (int i = 0; i < 3000; i++) begin
            v[6:4] = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(1, 7));
            v[3:0] = 4'($urandom_range(0, 3));
            ia     = ($urandom_range(0, 9) < 3);
            eo     = ($urandom_range(0, 9) < 3);
            r      = ($urandom_range(0, 199) == 0);
            step(r, v, ia, eo);
        end
        step(1'b0, 7'h00, 1'b0, 1'b0);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/c432_irq_seq.md
C432_IRQ_SEQ -- requirements
Module: c432_irq_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, request queue depth; SHALL be a power of two, 2..8.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: CK clocks all state, and RST resets it on the CK rising edge.
REQ-003 Ports:
- CK  in  1  clock; all flops on rising edge.
- RST  in  1  synchronous active-high reset.
- GRANT  in  3  per-bus grant flags from the upstream 27-channel priority encoder (bus A, B, C).
- CHAN  in  4  encoded winning channel from the upstream priority encoder.
- IACK  in  1  CPU interrupt acknowledge.
- EOI  in  1  CPU end-of-interrupt.
- IRQ  out  1  interrupt request to CPU.
- VEC  out  7  vector {GRANT,CHAN}.
- BUSY  out  1  high when state is not IDLE.
- CNT  out  3  queue occupancy.
- OVF  out  1  sticky flag for a dropped request.

Function
REQ-004 Sampled vector S = {GRANT,CHAN}; a request SHALL be valid when GRANT != 0.
REQ-005 The block SHALL register S every cycle into PREV (reset 0); capture SHALL occur when the request is valid and S != PREV, so a held level is queued once.
REQ-006 On capture, S SHALL be pushed to the FIFO tail if CNT < FIFO_DEPTH.
REQ-007 On capture at full, the request SHALL be dropped and OVF SHALL be set, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-008 CNT SHALL reflect occupancy after each edge; simultaneous push and pop SHALL leave CNT unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 FSM states SHALL be IDLE, REQ and SERV.
REQ-010 FSM transitions:
- IDLE -> REQ when CNT != 0.
- REQ -> SERV on IACK; the FIFO head is popped into register VREG.
- SERV -> IDLE on EOI.
REQ-011 IRQ SHALL be 1 only in REQ.
REQ-012 VEC output:
- In REQ, VEC SHALL equal the FIFO head.
- In SERV, VEC SHALL equal VREG.
- In IDLE, VEC SHALL be 0.
REQ-013 Latency: a request sampled at edge t SHALL appear in CNT after edge t, and IRQ SHALL be high after edge t+1 when the FSM is idle with an empty queue.
REQ-014 IACK outside REQ and EOI outside SERV SHALL be ignored; IACK and EOI together in REQ SHALL act as IACK only.
REQ-015 In SERV, capture and queueing SHALL continue; the next request SHALL be raised at the earliest one cycle after IDLE is re-entered.
REQ-016 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-017 On RST the following SHALL be cleared, and RST SHALL take priority over all other events:
- State -> IDLE.
- CNT, pointers, PREV, VREG, OVF -> 0.
- IRQ, BUSY, VEC -> 0.
REQ-018 RST asserted during REQ or SERV SHALL abandon the in-flight vector and discard all queued entries.
REQ-019 OVF SHALL clear only on RST.

Configuration
REQ-020 The block SHALL use the macro C432_IRQ_SEQ_FIFO_EN, with and without it as follows:
- Defined: queue of FIFO_DEPTH entries as specified above.
- Undefined: a single holding register replaces the FIFO, FIFO_DEPTH is ignored, CNT is 0 or 1, and a capture while full sets OVF under the same rules.

Verification
REQ-021 After RST, GRANT=3'b001 and CHAN=4'h5 for 1 cycle -> CNT=1 after edge 1, IRQ=1 and VEC=7'h15 after edge 2; IACK -> BUSY=1, IRQ=0; EOI -> IDLE, VEC=0.
REQ-022 GRANT=3'b010 and CHAN=4'h3 held for 10 cycles -> exactly one capture, CNT=1.
REQ-023 With the macro defined, 5 distinct requests (7'h11, 7'h12, 7'h13, 7'h14, 7'h15) and no IACK -> CNT=4, OVF=1; after successive IACK/EOI pairs, VEC order is 11,12,13,14.
REQ-024 With the queue full, a new capture coincident with IACK -> push accepted, CNT stays 4, OVF unchanged.
REQ-025 RST asserted in SERV with CNT=2 -> next cycle IDLE, CNT=0, IRQ=0, VEC=0, OVF=0.
REQ-026 With the macro undefined, two distinct requests 7'h21 then 7'h22 without IACK -> CNT=1, VEC=7'h21, OVF=1.
